// File: rtl/seven_tube_pkg.sv
// Shared definitions for the six-digit seven-segment display path.
// The segment table lives here so the scanning driver and this decoder
// agree on the exact same glyph codes.
package seven_tube_pkg;

   // Number of scanned digits; sel values 0..DIGIT_NUM-1 are meaningful.
   localparam int DIGIT_NUM = 6;

   // Active-low segment codes {dp,g,f,e,d,c,b,a} with the dp segment off.
   // Entry i is the glyph for hex digit i.
   localparam logic [15:0][7:0] SEG_CODE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
      8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
      8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
      8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
   };

   // All segments off, including the decimal point.
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Decoder result: err set when the pattern is not one of the 16 glyphs.
   typedef struct packed {
      logic       err;
      logic [3:0] nib;
   } seg_dec_t;

   // Map the seven glyph segments {g..a} back to a hex nibble.
   // Anything outside the table (blank included) reports err with nibble 0.
   function automatic seg_dec_t seg_to_hex(input logic [6:0] i_seg7);
      seg_dec_t r_res;
      r_res.err = 1'b0;
      r_res.nib = 4'h0;
      case (i_seg7)
         SEG_CODE[0][6:0]:  r_res.nib = 4'h0;
         SEG_CODE[1][6:0]:  r_res.nib = 4'h1;
         SEG_CODE[2][6:0]:  r_res.nib = 4'h2;
         SEG_CODE[3][6:0]:  r_res.nib = 4'h3;
         SEG_CODE[4][6:0]:  r_res.nib = 4'h4;
         SEG_CODE[5][6:0]:  r_res.nib = 4'h5;
         SEG_CODE[6][6:0]:  r_res.nib = 4'h6;
         SEG_CODE[7][6:0]:  r_res.nib = 4'h7;
         SEG_CODE[8][6:0]:  r_res.nib = 4'h8;
         SEG_CODE[9][6:0]:  r_res.nib = 4'h9;
         SEG_CODE[10][6:0]: r_res.nib = 4'hA;
         SEG_CODE[11][6:0]: r_res.nib = 4'hB;
         SEG_CODE[12][6:0]: r_res.nib = 4'hC;
         SEG_CODE[13][6:0]: r_res.nib = 4'hD;
         SEG_CODE[14][6:0]: r_res.nib = 4'hE;
         SEG_CODE[15][6:0]: r_res.nib = 4'hF;
         default: begin
            r_res.err = 1'b1;
            r_res.nib = 4'h0;
         end
      endcase
      return r_res;
   endfunction

endpackage

// File: rtl/seven_tube_seg_dec.sv
// Combinational glyph decoder: seven active-low segments to {err,nibble}.
// Thin wrapper around the package table so every user decodes identically.
module seven_tube_seg_dec
   import seven_tube_pkg::*;
(
   input  logic [6:0] i_seg7,
   output logic [3:0] o_nibble,
   output logic       o_err
);

   seg_dec_t w_dec;

   // Table lookup; no state.
   always_comb begin
      w_dec = seg_to_hex(i_seg7);
   end

   assign o_nibble = w_dec.nib;
   assign o_err    = w_dec.err;

endmodule

// File: rtl/seven_tube_decode.sv
// Receive side of the multiplexed seven-segment bus. Registers the scanned
// sel/seg bus, waits for each digit dwell to settle, decodes the glyph and
// reassembles a full six-digit frame with decimal points and an error flag.
module seven_tube_decode
   import seven_tube_pkg::*;
#(
   // Identical registered samples required before a dwell is captured (>= 2).
   parameter int STABLE_CNT = 4,
   // Stability counter width; 2**CNT_W must exceed STABLE_CNT.
   parameter int CNT_W      = 8
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic [2:0]             sel_in,
   input  logic [7:0]             seg_in,
   output logic [4*DIGIT_NUM-1:0] data_out,
   output logic [DIGIT_NUM-1:0]   dp_out,
   output logic                   data_valid,
   output logic                   err_out
);

   localparam logic [0:0] ST_WAIT = 1'b0;
   localparam logic [0:0] ST_HELD = 1'b1;

   localparam logic [CNT_W-1:0]     CNT_SAT   = CNT_W'(STABLE_CNT);
   localparam logic [CNT_W-1:0]     CNT_CAP   = CNT_W'(STABLE_CNT - 1);
   localparam logic [DIGIT_NUM-1:0] MASK_FULL = '1;

   // Input sample registers
   logic [2:0]             r_sel_q;
   logic [7:0]             r_seg_q;

   // Dwell tracking
   logic [CNT_W-1:0]       r_cnt;
   logic [0:0]             r_state;

   // Partial frame being assembled
   logic [4*DIGIT_NUM-1:0] r_shadow;
   logic [DIGIT_NUM-1:0]   r_shadow_dp;
   logic [DIGIT_NUM-1:0]   r_mask;
   logic                   r_frame_err;

   // Combinational helpers
   logic                   w_same;
   logic                   w_cap;
   logic                   w_in_range;
   logic                   w_cap_ok;
   logic [7:0]             w_hot8;
   logic [DIGIT_NUM-1:0]   w_slot_hot;
   logic [3:0]             w_dec_nib;
   logic                   w_dec_err;
   logic [4*DIGIT_NUM-1:0] w_shadow_nxt;
   logic [DIGIT_NUM-1:0]   w_dp_nxt;
   logic [DIGIT_NUM-1:0]   w_mask_nxt;
   logic                   w_err_nxt;
   logic                   w_frame_done;

   seven_tube_seg_dec u_seg_dec (
      .i_seg7   (r_seg_q[6:0]),
      .o_nibble (w_dec_nib),
      .o_err    (w_dec_err)
   );

   // A dwell is stable while the live bus matches the registered sample.
   // Capture happens once per dwell, on the edge the counter reaches its
   // last pre-saturation value while still in WAIT.
   always_comb begin
      w_same     = ({sel_in, seg_in} == {r_sel_q, r_seg_q});
      w_cap      = w_same && (r_state == ST_WAIT) && (r_cnt == CNT_CAP);
      w_hot8     = 8'b1 << r_sel_q;
      // sel 6 and 7 are not digit slots and are silently dropped.
      w_in_range = ~|w_hot8[7:DIGIT_NUM];
      w_cap_ok   = w_cap && w_in_range;
      w_slot_hot = w_cap_ok ? w_hot8[DIGIT_NUM-1:0] : '0;
   end

   // Next-state of the partial frame, including the digit captured this edge.
   always_comb begin
      w_shadow_nxt = r_shadow;
      w_dp_nxt     = r_shadow_dp;
      for (int k = 0; k < DIGIT_NUM; k++) begin
         if (w_slot_hot[k]) begin
            w_shadow_nxt[4*k +: 4] = w_dec_nib;
            w_dp_nxt[k]            = ~r_seg_q[7];
         end
      end
      w_mask_nxt   = r_mask | w_slot_hot;
      w_err_nxt    = r_frame_err | (w_cap_ok & w_dec_err);
      w_frame_done = w_cap_ok && (w_mask_nxt == MASK_FULL);
   end

   // Register the scanned bus every cycle.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_sel_q <= '0;
         r_seg_q <= '0;
      end else begin
         r_sel_q <= sel_in;
         r_seg_q <= seg_in;
      end
   end

   // Stability counter and WAIT/HELD state; any bus change restarts the dwell.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cnt   <= '0;
         r_state <= ST_WAIT;
      end else if (!w_same) begin
         r_cnt   <= '0;
         r_state <= ST_WAIT;
      end else begin
         if (r_cnt != CNT_SAT) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_cap) begin
            r_state <= ST_HELD;
         end
      end
   end

   // Shadow frame, slot mask and error flag; mask and error restart per frame.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_shadow    <= '0;
         r_shadow_dp <= '0;
         r_mask      <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_shadow    <= w_shadow_nxt;
         r_shadow_dp <= w_dp_nxt;
         if (w_frame_done) begin
            r_mask      <= '0;
            r_frame_err <= 1'b0;
         end else begin
            r_mask      <= w_mask_nxt;
            r_frame_err <= w_err_nxt;
         end
      end
   end

   // Publish a completed frame and pulse data_valid; outputs hold otherwise.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         data_out   <= '0;
         dp_out     <= '0;
         err_out    <= 1'b0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= w_frame_done;
         if (w_frame_done) begin
            data_out <= w_shadow_nxt;
            dp_out   <= w_dp_nxt;
            err_out  <= w_err_nxt;
         end
      end
   end

endmodule

// File: tb/tb_seven_tube_decode.sv
// Directed bench for seven_tube_decode: nominal scan, settle latency and
// glitch rejection, bad glyphs, out-of-range/repeated slots, decimal points
// and reset in the middle of a frame.
`timescale 1ns/100ps
module tb_seven_tube_decode;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [2:0]  sel_in = 3'd7;
   logic [7:0]  seg_in = 8'hFF;
   logic [23:0] data_out;
   logic [5:0]  dp_out;
   logic        data_valid;
   logic        err_out;

   int total = 0;
   int bad   = 0;

   // Frame monitor state
   int          vld_cnt = 0;
   logic [23:0] last_data = '0;
   logic [5:0]  last_dp = '0;
   logic        last_err = 1'b0;

   // sel 0..5 carry digits 5,4,3,2,1,0 -> display word 012345
   localparam logic [47:0] NOM = {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};

   logic [47:0] pat;
   logic [10:0] oor_seq [9];
   int          v0;

   seven_tube_decode #(.STABLE_CNT(4), .CNT_W(8)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .sel_in     (sel_in),
      .seg_in     (seg_in),
      .data_out   (data_out),
      .dp_out     (dp_out),
      .data_valid (data_valid),
      .err_out    (err_out)
   );

   always #10 sys_clk = ~sys_clk;

   // Count valid pulses and snapshot the reported frame.
   always @(negedge sys_clk) begin
      if (data_valid === 1'b1) begin
         vld_cnt   <= vld_cnt + 1;
         last_data <= data_out;
         last_dp   <= dp_out;
         last_err  <= err_out;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one dwell for n rising edges; returns 1 ns after the last one.
   task automatic dwell(input logic [2:0] s, input logic [7:0] g, input int n);
      sel_in = s;
      seg_in = g;
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic scan(input logic [47:0] segs, input int n);
      for (int k = 0; k < 6; k++) dwell(3'(k), segs[8*k +: 8], n);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      oor_seq = '{ {3'd0, 8'h92}, {3'd1, 8'h99}, {3'd6, 8'hC0},
                   {3'd2, 8'hB0}, {3'd3, 8'hA4}, {3'd7, 8'h80},
                   {3'd3, 8'h88}, {3'd4, 8'hF9}, {3'd5, 8'hC0} };

      // Reset state
      #100;
      chk("rst_data", 32'(data_out), 32'h0);
      chk("rst_dp", 32'(dp_out), 32'h0);
      chk("rst_vld", 32'(data_valid), 32'h0);
      chk("rst_err", 32'(err_out), 32'h0);
      #100.1 sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;

      // Nominal loopback, two full scans with long dwells
      v0 = vld_cnt;
      scan(NOM, 1000);
      scan(NOM, 1000);
      chk("nom_pulses", 32'(vld_cnt - v0), 32'd2);
      chk("nom_data", 32'(last_data), 32'h012345);
      chk("nom_dp", 32'(last_dp), 32'h0);
      chk("nom_err", 32'(last_err), 32'h0);
      chk("nom_hold", 32'(data_out), 32'h012345);

      // Glitch rejection then exact capture latency on the closing digit
      v0 = vld_cnt;
      pat = NOM;
      for (int k = 0; k < 5; k++) dwell(3'(k), pat[8*k +: 8], 10);
      dwell(3'd5, 8'h80, 3);
      chk("glitch_nocap", 32'(vld_cnt - v0), 32'd0);
      sel_in = 3'd5;
      seg_in = 8'hC0;
      for (int k = 0; k < 6; k++) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
         chk($sformatf("lat_e%0d", k), 32'(data_valid), 32'(k == 4));
      end
      @(posedge sys_clk);
      #1;
      chk("lat_pulses", 32'(vld_cnt - v0), 32'd1);
      chk("lat_data", 32'(last_data), 32'h012345);

      // Undecodable glyph at sel 2, then a clean frame
      v0 = vld_cnt;
      pat = NOM;
      pat[23:16] = 8'hFF;
      scan(pat, 10);
      chk("inv_pulses", 32'(vld_cnt - v0), 32'd1);
      chk("inv_data", 32'(last_data), 32'h012045);
      chk("inv_err", 32'(last_err), 32'h1);
      scan(NOM, 10);
      chk("clean_data", 32'(last_data), 32'h012345);
      chk("clean_err", 32'(last_err), 32'h0);

      // Out-of-range sel values and a repeated slot 3 with a new glyph
      v0 = vld_cnt;
      for (int k = 0; k < 8; k++) dwell(oor_seq[k][10:8], oor_seq[k][7:0], 10);
      chk("oor_noearly", 32'(vld_cnt - v0), 32'd0);
      dwell(oor_seq[8][10:8], oor_seq[8][7:0], 10);
      chk("oor_pulses", 32'(vld_cnt - v0), 32'd1);
      chk("oor_data", 32'(last_data), 32'h01A345);
      chk("oor_err", 32'(last_err), 32'h0);

      // Decimal points lit at sel 0 and sel 4
      pat = NOM;
      pat[7:0]   = 8'h12;
      pat[39:32] = 8'h79;
      scan(pat, 10);
      chk("dp_bits", 32'(last_dp), 32'h11);
      chk("dp_data", 32'(last_data), 32'h012345);

      // Reset after three captured digits
      v0 = vld_cnt;
      for (int k = 0; k < 3; k++) dwell(3'(k), NOM[8*k +: 8], 10);
      chk("prerst_data", 32'(data_out), 32'h012345);
      sys_rst_n = 1'b0;
      sel_in = 3'd7;
      seg_in = 8'hFF;
      #2;
      chk("mid_rst_data", 32'(data_out), 32'h0);
      chk("mid_rst_dp", 32'(dp_out), 32'h0);
      chk("mid_rst_vld", 32'(data_valid), 32'h0);
      repeat (3) @(posedge sys_clk);
      #5 sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;
      for (int k = 3; k < 6; k++) dwell(3'(k), NOM[8*k +: 8], 10);
      chk("rst_noearly", 32'(vld_cnt - v0), 32'd0);
      for (int k = 0; k < 3; k++) dwell(3'(k), NOM[8*k +: 8], 10);
      chk("rst_pulses", 32'(vld_cnt - v0), 32'd1);
      chk("rst_reframe", 32'(last_data), 32'h012345);
      chk("rst_dp_after", 32'(last_dp), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seven_tube_decode.md
Name: seven_tube_decode

Overview:
- Receive-side counterpart of the six-digit multiplexed seven-segment driver.
- Samples the scanned sel/seg bus and waits for each digit dwell to settle.
- Decodes each segment pattern back to a hex nibble plus its decimal-point bit, and reassembles the 24-bit display word.
- Used as a loopback checker in FPGA self-test and as a scoreboard front end in display benches.

Parameters:
- DIGIT_NUM, 6, number of scanned digits. Fixed at 6 for this revision; valid sel values are 0..5.
- STABLE_CNT, 4, consecutive identical registered samples required before a dwell is captured. Minimum 2.
- CNT_W, 8, width of the stability counter. Must satisfy 2^CNT_W > STABLE_CNT.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- sel_in  in  3  binary digit index from the scanning driver.
- seg_in  in  8  segment bus, active-low, {dp,g,f,e,d,c,b,a}.
- data_out  out  24  last complete frame; the digit at sel=k occupies bits [4k+3:4k].
- dp_out  out  6  last complete frame's decimal points, active-high; dp_out[k] = ~seg_in[7] at sel=k.
- data_valid  out  1  one-cycle pulse, high when data_out, dp_out and err_out update.
- err_out  out  1  high if any digit in the reported frame carried an undecodable pattern.

Behaviour:
- Reset: asynchronous, active-low. All registers clear: data_out=0, dp_out=0, data_valid=0, err_out=0, capture mask=0, shadow=0, counter=0, FSM=WAIT.
- Input stage: sel_in and seg_in are registered once into sel_q/seg_q every cycle.
- Stability counter:
  - If {sel_in,seg_in} != {sel_q,seg_q}, counter <= 0 and FSM <= WAIT.
  - Otherwise counter <= counter+1, saturating at STABLE_CNT.
- FSM states: WAIT and HELD.
  - WAIT -> HELD on the edge where counter == STABLE_CNT-1 and inputs are unchanged. That edge is the capture edge.
  - HELD -> WAIT only on an input change. Exactly one capture occurs per dwell.
- Capture latency: an input change registered at edge E0 is captured at edge E_STABLE_CNT. Glitches shorter than STABLE_CNT cycles are never captured.
- Capture with sel_q < 6:
  - Decode seg_q[6:0] to a nibble: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (values are {1,g..a} in hex).
  - Write the nibble into shadow slot sel_q and ~seg_q[7] into the shadow dp bit.
  - Set mask bit sel_q.
- Undecodable pattern (including blank 7F): the nibble is written as 0 and the frame error flag is set.
- Capture with sel_q = 6 or 7: ignored. No shadow write, no mask change, no error.
- Repeated slot before the frame completes: shadow slot is overwritten, mask unchanged, no error.
- Frame completion: on the capture edge where the mask becomes all-ones:
  - data_out <= shadow including the new nibble.
  - dp_out <= shadow dp bits.
  - err_out <= frame error flag, including the current digit.
  - data_valid <= 1 for one cycle.
  - Mask and frame error flag clear on that same edge.
- data_out, dp_out and err_out hold their values between frames.
- Reset mid-frame discards the partial frame. Outputs return to their reset values; data_valid does not pulse.

Decomposition:
- Package seven_tube_pkg holds:
  - DIGIT_NUM.
  - The 16-entry active-low segment code constants, shared with the driver.
  - SEG_BLANK = 8'hFF.
  - A function seg_to_hex returning {err,nibble[3:0]}.
- One sub-module, seven_tube_seg_dec: purely combinational 7-bit to {err,nibble} decoder, so driver and checker share one table.
- Top level holds the input registers, stability counter, FSM, shadow, mask and output registers.

Test Plan:
- Nominal loopback: drive the 012345 scan pattern (sel 0..5, seg C0,F9,A4,B0,99,92 at sel 5..0), 1000 cycles per dwell, after releasing reset at 200.1 ns → data_valid pulses once per scan cycle and data_out = 24'h012345, dp_out = 0, err_out = 0.
- Latency and glitch: hold a dwell for STABLE_CNT-1 cycles, then change it → no capture. Hold a dwell steady → capture exactly 4 edges after the registering edge. data_valid is high for exactly 1 cycle.
- Invalid pattern: drive seg = 8'hFF at sel = 2 within an otherwise valid frame → data_out[11:8] = 0, err_out = 1 for that frame; the next clean frame gives err_out = 0.
- Out-of-range and repeat: insert sel = 6 and 7 dwells, and repeat sel = 3 with a new pattern 88 before the frame completes → the frame still completes after slots 0..5, with data_out[15:12] = 4'hA.
- DP bits: clear seg[7] at sel = 0 and sel = 4 → dp_out = 6'b010001.
- Reset mid-frame: assert sys_rst_n low after 3 digits are captured → all outputs 0 immediately. After release, the first data_valid occurs only after all 6 slots are captured anew.
